// File: rtl/fp_ci_issuer.sv
// rtl/fp_ci_issuer.sv - initiator for the multi-cycle FP custom-instruction start/done handshake
// Optional done watchdog is compiled in when FP_CI_TIMEOUT_EN is defined.
module fp_ci_issuer #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dataa,
  input  logic [DATA_W-1:0] in_datab,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  output logic [DATA_W-1:0] ci_datab,
  input  logic [DATA_W-1:0] ci_result,
  input  logic              ci_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output logic              timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_ci_start;
  logic [DATA_W-1:0]   r_ci_dataa;
  logic [DATA_W-1:0]   r_ci_datab;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_result;
  logic [CNT_W-1:0]    r_op_count;

`ifdef FP_CI_TIMEOUT_EN
  localparam int WC_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WC_W-1:0]   WC_LAST = WC_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] QNAN    = DATA_W'(32'h7FC0_0000);

  logic [WC_W-1:0] r_wait_cnt;
  logic            r_timeout;
`endif

  // Every output is a register; done is only looked at in WAIT, so a level-type
  // done that lingers through HOLD/IDLE/ISSUE can never trigger a second capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_ci_start   <= 1'b0;
      r_ci_dataa   <= '0;
      r_ci_datab   <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_op_count   <= '0;
`ifdef FP_CI_TIMEOUT_EN
      r_wait_cnt   <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ci_dataa <= in_dataa;
            r_ci_datab <= in_datab;
            r_ci_start <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_ci_start <= 1'b0;
`ifdef FP_CI_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (ci_done) begin
            r_out_result <= ci_result;
            r_out_valid  <= 1'b1;
            r_op_count   <= r_op_count + 1'b1;
            r_state      <= S_HOLD;
          end
`ifdef FP_CI_TIMEOUT_EN
          // done on the final allowed cycle takes priority over the watchdog
          else if (r_wait_cnt == WC_LAST) begin
            r_out_result <= QNAN;
            r_out_valid  <= 1'b1;
            r_timeout    <= 1'b1;
            r_state      <= S_HOLD;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign ci_start   = r_ci_start;
  assign ci_dataa   = r_ci_dataa;
  assign ci_datab   = r_ci_datab;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign op_count   = r_op_count;

`ifdef FP_CI_TIMEOUT_EN
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fp_ci_issuer.sv
// tb/tb_fp_ci_issuer.sv - randomized scoreboard bench for fp_ci_issuer with a stub FP unit
module tb_fp_ci_issuer;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int TO = 8;
  localparam int CNT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_dataa = '0;
  logic [DW-1:0] in_datab = '0;
  logic          ci_start;
  logic [DW-1:0] ci_dataa;
  logic [DW-1:0] ci_datab;
  logic [DW-1:0] ci_result = '0;
  logic          ci_done = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_result;
  logic          busy;
  logic [CW-1:0] op_count;
  logic          timeout;

  fp_ci_issuer #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dataa(in_dataa), .in_datab(in_datab),
    .ci_start(ci_start), .ci_dataa(ci_dataa), .ci_datab(ci_datab),
    .ci_result(ci_result), .ci_done(ci_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy), .op_count(op_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] res; int k; int hold; } op_t;
  typedef struct { logic [31:0] res; bit counts; int lat; } exp_t;

  op_t  stub_q[$];
  exp_t sb_q[$];
  int   start_q[$];
  int   start_log[$];

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;
  int exp_cnt = 0;
  int n_acc = 0;
  int stall_next = 0;
  int stall_left = 0;
  int vcycles = 0;
  int last_vcycles = 0;
  bit rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stub FP unit: done after k cycles in WAIT, held for 'hold' cycles; k=0 never answers.
  initial begin : stub
    op_t o;
    forever begin
      @(negedge clk);
      if (reset_n && ci_start) begin
        if (stub_q.size() == 0) begin
          check("stub_unexpected_start", 32'd1, 32'd0);
        end else begin
          o = stub_q.pop_front();
          check("start_dataa", ci_dataa, o.a);
          check("start_datab", ci_datab, o.b);
          if (o.k > 0) begin
            repeat (o.k) @(posedge clk);
            #1;
            ci_done   = 1'b1;
            ci_result = o.res;
            check("done_dataa_stable", ci_dataa, o.a);
            check("done_datab_stable", ci_datab, o.b);
            repeat (o.hold) @(posedge clk);
            #1;
            ci_done   = 1'b0;
            ci_result = $urandom;
          end
        end
      end
    end
  end

  // Consumer: optional stall cycles once a result is presented, random ready otherwise.
  initial begin : consumer
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted result.
  initial begin : monitor
    bit   prev_start;
    bit   prev_valid;
    exp_t e;
    prev_start = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_start = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (ci_start) begin
          start_q.push_back(cyc);
          start_log.push_back(cyc);
          check("start_single_cycle", 32'(prev_start), 32'd0);
        end
        prev_start = ci_start;
        if (out_valid && !prev_valid) begin
          vcycles = 0;
          if (start_q.size() == 0 || sb_q.size() == 0)
            check("valid_without_start", 32'd1, 32'd0);
          else
            check("latency", 32'(cyc - start_q.pop_front()), 32'(sb_q[0].lat));
        end
        if (out_valid) vcycles++;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("out_result", out_result, e.res);
            if (e.counts) exp_cnt = (exp_cnt + 1) % CNT_MOD;
            check("op_count", 32'(op_count), 32'(exp_cnt));
            last_vcycles = vcycles;
            stall_left   = stall_next;
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                       input int k, input int hold, input bit counts, input int lat);
    op_t  o;
    exp_t e;
    int   guard;
    guard    = 0;
    in_valid = 1'b1;
    in_dataa = a;
    in_datab = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 300) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    o.a = a; o.b = b; o.res = res; o.k = k; o.hold = hold;
    e.res = res; e.counts = counts; e.lat = lat;
    stub_q.push_back(o);
    sb_q.push_back(e);
    n_acc++;
    in_valid = 1'b0;
    in_dataa = $urandom;
    in_datab = $urandom;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 || out_valid) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 500) begin
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
        return;
      end
    end
  endtask

  task automatic rand_op();
    int k;
    k = $urandom_range(1, 6);
    stall_next = $urandom_range(0, 2);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    issue($urandom, $urandom, $urandom, k, $urandom_range(1, 3), 1'b1, k + 1);
  endtask

  initial begin : main
    int idx0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ci_start", 32'(ci_start), 32'd0);
    check("rst_ci_dataa", ci_dataa, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // single operation
    issue(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5, 1, 1'b1, 6);
    drain();
    check("single_result", out_result, 32'h4040_0000);
    check("single_op_count", 32'(op_count), 32'd1);

    // level done held 10 cycles, consumer stalls 3 cycles
    rand_ready = 1'b1;
    stall_left = 3;
    stall_next = 0;
    issue($urandom, $urandom, 32'hC0DE_0001, 2, 10, 1'b1, 3);
    drain();
    repeat (12) @(posedge clk);
    #1;
    check("level_valid_cycles", 32'(last_vcycles), 32'd4);
    check("level_op_count", 32'(op_count), 32'd2);
    check("level_start_count", 32'(start_log.size()), 32'(n_acc));

    // back-to-back with in_valid held high
    idx0 = start_log.size();
    for (int i = 0; i < 4; i++)
      issue($urandom, $urandom, $urandom, 1, 1, 1'b1, 2);
    drain();
    check("b2b_op_count", 32'(op_count), 32'd6);
    for (int i = 1; i < 4; i++)
      check("b2b_start_spacing", 32'(start_log[idx0+i] - start_log[idx0+i-1]), 32'd4);

    // reset while waiting on an unanswered operation
    issue($urandom, $urandom, $urandom, 0, 1, 1'b1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midwait_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    sb_q.delete();
    start_q.delete();
    stub_q.delete();
    exp_cnt = 0;
    check("midrst_ci_start", 32'(ci_start), 32'd0);
    check("midrst_ci_datab", ci_datab, 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_op_count", 32'(op_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // counter wrap: 2^CW operations bring op_count back to 0
    for (int i = 0; i < CNT_MOD; i++) rand_op();
    drain();
    check("wrap_op_count", 32'(op_count), 32'd0);

    for (int i = 0; i < 20; i++) rand_op();
    drain();

`ifdef FP_CI_TIMEOUT_EN
    stall_next = 0;
    issue($urandom, $urandom, 32'h1234_5678, TO, 1, 1'b1, TO + 1);
    drain();
    check("to_edge_no_timeout", 32'(timeout), 32'd0);
    issue($urandom, $urandom, $urandom, 0, 1, 1'b0, TO + 1);
    drain();
    check("to_flag", 32'(timeout), 32'd1);
    check("to_result", out_result, 32'h7FC0_0000);
    check("to_op_count", 32'(op_count), 32'(exp_cnt));
    rand_op();
    drain();
    check("to_sticky", 32'(timeout), 32'd1);
`else
    check("timeout_tied_low", 32'(timeout), 32'd0);
`endif

    check("total_starts", 32'(start_log.size()), 32'(n_acc));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
